pw_program_fsm: RTL and testbench
=================================

PW_PROGRAM_FSM -- requirements
Module: pw_program_fsm

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-003 The module SHALL have port prog_en, input, 1 bit: programming-mode enable, level-sensitive.
REQ-004 The module SHALL have port comb_in, input, 10 bits: switch bank, where bit k set means digit k.
REQ-005 The module SHALL have port pw_digits, output, 16 bits: stored password, [15:12] = first digit, BCD.
REQ-006 The module SHALL have port pw_update, output, 1 bit: one-cycle pulse when a new password is committed.
REQ-007 The module SHALL have port saved, output, 1 bit: high while in DONE.
REQ-008 The module SHALL have port error, output, 1 bit: high while in ERROR.
REQ-009 The module SHALL have port states, output, 10 bits: progress LEDs.
REQ-010 The module SHALL have ports d0, d1, d2, d3 and d4, output, 7 bits each: 7-segment digits, active-low, bit order {g,f,e,d,c,b,a}, d4 leftmost.

Function
REQ-011 comb_in SHALL be registered once; a press event SHALL fire when the registered value is zero and the current comb_in is nonzero, for one cycle per press.
REQ-012 A press SHALL be valid only if exactly one bit is set; the digit value SHALL be the index of that bit (0-9).
REQ-013 FSM states SHALL be IDLE, ENTER, CONFIRM, DONE and ERROR, with a 2-bit digit counter cnt.
REQ-014 IDLE: when prog_en=1, the FSM SHALL go to ENTER with cnt=0; presses in IDLE SHALL be ignored.
REQ-015 ENTER: on a valid press, shadow[cnt] SHALL be set to the digit and cnt SHALL increment; after the 4th digit the FSM SHALL go to CONFIRM with cnt=0.
REQ-016 CONFIRM: a valid press matching shadow[cnt] SHALL increment cnt; a 4th matching press SHALL go to DONE.
REQ-017 On entering DONE, pw_digits SHALL be loaded from shadow and pw_update SHALL pulse high for exactly that one cycle.
REQ-018 In ENTER or CONFIRM, an invalid (multi-bit) press or a CONFIRM mismatch SHALL go to ERROR; pw_digits SHALL remain unchanged.
REQ-019 In DONE or ERROR, the next press event of any kind SHALL go to IDLE.
REQ-020 In ENTER or CONFIRM, prog_en=0 SHALL abort to IDLE with no commit, and SHALL take priority over a same-cycle press.
REQ-021 prog_en SHALL be ignored in DONE and ERROR.
REQ-022 Holding a switch SHALL generate no further events; a switch change while comb_in is nonzero SHALL generate no event.
REQ-023 Outputs saved, error, states and d0-d4 SHALL be Moore outputs decoded from the registered state and cnt only.
REQ-024 states SHALL be: IDLE = 10'b0000000001; ENTER = bit0 plus bits[cnt:1] thermometer; CONFIRM = bits[4:0] set plus bits[cnt+4:5] thermometer; DONE = 10'b0111111111; ERROR = 10'b1000000000.
REQ-025 In IDLE, d0-d4 SHALL all be 7'b1111111 (blank).
REQ-026 In ENTER and CONFIRM, d4 SHALL be blank and one dash (7'b0111111) SHALL be shown per digit entered, filling d3 first, then d2, d1, d0; the rest blank.
REQ-027 In DONE, d4 SHALL be blank and d3-d0 SHALL show the stored digits as standard hex patterns (9=0010000, 8=0000000, 7=1111000, 6=0000010, 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010).
REQ-028 In ERROR, d4..d0 SHALL show "Error": 0000110, 0101111, 0101111, 0100011, 0101111.

Reset
REQ-029 While rst=1 the FSM SHALL be in IDLE, cnt and shadow SHALL be 0, the comb_in register SHALL be 0, and pw_digits SHALL be 16'h9876.
REQ-030 While rst=1, pw_update, saved and error SHALL be 0, states SHALL be 10'b0000000001, and all displays SHALL be blank.
REQ-031 rst SHALL override all other inputs, including mid-entry; a rst during CONFIRM SHALL restore pw_digits to 16'h9876.

Verification
REQ-032 Reset, then prog_en=1 with presses 1,2,3,4,1,2,3,4 (each pulse followed by zero) -> DONE, pw_digits=16'h1234, one pw_update pulse, states=10'b0111111111.
REQ-033 Enter 1,2,3,4, then confirm 1,2,5 -> ERROR on the 5 press, pw_digits unchanged at 16'h9876, display "Error", states=10'b1000000000.
REQ-034 comb_in=10'b0000000110 during ENTER -> ERROR; the next single press -> IDLE.
REQ-035 During ENTER, hold a digit for 10 cycles -> cnt advances by 1 only; drop prog_en after 2 digits, in the same cycle as a press -> IDLE, no commit.
REQ-036 After committing 16'h1234, assert rst for 1 cycle -> pw_digits=16'h9876, IDLE outputs.

Source files
------------

// File: rtl/pw_program_fsm.sv
// Password programming sequencer: capture four digits, confirm them, then commit.
// Drives progress LEDs and a five-digit active-low 7-segment display.
module pw_program_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic        prog_en,
    input  logic [9:0]  comb_in,
    output logic [15:0] pw_digits,
    output logic        pw_update,
    output logic        saved,
    output logic        error,
    output logic [9:0]  states,
    output logic [6:0]  d0,
    output logic [6:0]  d1,
    output logic [6:0]  d2,
    output logic [6:0]  d3,
    output logic [6:0]  d4
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ENTER   = 3'd1;
    localparam logic [2:0] S_CONFIRM = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_ERROR   = 3'd4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    logic [2:0]      state;
    logic [1:0]      cnt;
    logic [3:0][3:0] shadow;
    logic [9:0]      comb_q;
    logic            press;
    logic            one_hot;
    logic [3:0]      digit;

    // A press is the rising edge of "any switch on"; changes while held are not events.
    assign press   = (comb_q == '0) && (comb_in != '0);
    assign one_hot = (comb_in != '0) && ((comb_in & (comb_in - 10'd1)) == '0);

    always_comb begin
        digit = '0;
        for (int k = 0; k < 10; k++) begin
            if (comb_in[k]) digit = 4'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            shadow    <= '0;
            comb_q    <= '0;
            pw_digits <= 16'h9876;
            pw_update <= 1'b0;
        end else begin
            comb_q    <= comb_in;
            pw_update <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (prog_en) begin
                        state <= S_ENTER;
                        cnt   <= '0;
                    end
                end
                S_ENTER: begin
                    if (!prog_en) begin
                        state <= S_IDLE;
                    end else if (press) begin
                        if (!one_hot) begin
                            state <= S_ERROR;
                        end else begin
                            shadow[cnt] <= digit;
                            cnt         <= cnt + 2'd1;
                            if (cnt == 2'd3) state <= S_CONFIRM;
                        end
                    end
                end
                S_CONFIRM: begin
                    if (!prog_en) begin
                        state <= S_IDLE;
                    end else if (press) begin
                        if (!one_hot || digit != shadow[cnt]) begin
                            state <= S_ERROR;
                        end else begin
                            cnt <= cnt + 2'd1;
                            if (cnt == 2'd3) begin
                                state     <= S_DONE;
                                pw_digits <= {shadow[0], shadow[1], shadow[2], shadow[3]};
                                pw_update <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE, S_ERROR: begin
                    if (press) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        saved  = (state == S_DONE);
        error  = (state == S_ERROR);
        states = 10'b0000000001;
        d0     = SEG_BLANK;
        d1     = SEG_BLANK;
        d2     = SEG_BLANK;
        d3     = SEG_BLANK;
        d4     = SEG_BLANK;
        case (state)
            S_ENTER, S_CONFIRM: begin
                if (state == S_ENTER) begin
                    for (int k = 1; k < 4; k++) begin
                        if (k <= int'(cnt)) states[k] = 1'b1;
                    end
                end else begin
                    states = 10'b0000011111;
                    for (int k = 5; k < 8; k++) begin
                        if (k <= int'(cnt) + 4) states[k] = 1'b1;
                    end
                end
                // cnt tops out at 3 here, so d0 never gets a dash before the state moves on.
                if (cnt >= 2'd1) d3 = SEG_DASH;
                if (cnt >= 2'd2) d2 = SEG_DASH;
                if (cnt >= 2'd3) d1 = SEG_DASH;
            end
            S_DONE: begin
                states = 10'b0111111111;
                d3     = seg7(pw_digits[15:12]);
                d2     = seg7(pw_digits[11:8]);
                d1     = seg7(pw_digits[7:4]);
                d0     = seg7(pw_digits[3:0]);
            end
            S_ERROR: begin
                states = 10'b1000000000;
                d4     = 7'b0000110;
                d3     = 7'b0101111;
                d2     = 7'b0101111;
                d1     = 7'b0100011;
                d0     = 7'b0101111;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pw_program_fsm.sv
// Bench for pw_program_fsm: directed scenarios plus randomized programming attempts,
// all checked cycle by cycle against a behavioural model through an expected queue.
module tb_pw_program_fsm;

    logic        clk;
    logic        rst;
    logic        prog_en;
    logic [9:0]  comb_in;
    logic [15:0] pw_digits;
    logic        pw_update;
    logic        saved;
    logic        error;
    logic [9:0]  states;
    logic [6:0]  d0, d1, d2, d3, d4;

    pw_program_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .prog_en   (prog_en),
        .comb_in   (comb_in),
        .pw_digits (pw_digits),
        .pw_update (pw_update),
        .saved     (saved),
        .error     (error),
        .states    (states),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .d4        (d4)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [63:0] exp_q[$];
    logic [15:0] exp_commit_q[$];
    int          n_vec  = 0;
    int          n_err  = 0;
    int          n_upd  = 0;
    int          cyc    = 0;

    // ---------------- behavioural reference model ----------------
    typedef enum int {M_IDLE, M_ENTER, M_CONFIRM, M_DONE, M_ERROR} mode_t;
    mode_t       m_mode;
    int          m_ent[$];
    int          m_conf;
    logic [15:0] m_pw;
    logic [9:0]  m_prev;
    logic        m_upd;

    function automatic logic [6:0] hex_seg(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int digit_of(input logic [9:0] v);
        int d = 0;
        for (int k = 0; k < 10; k++) if (v[k]) d = k;
        return d;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [9:0] c);
        logic press;
        logic one;
        int   dig;
        m_upd = 1'b0;
        if (r) begin
            m_mode = M_IDLE;
            m_ent.delete();
            m_conf = 0;
            m_pw   = 16'h9876;
            m_prev = '0;
            return;
        end
        press = (m_prev == 0) && (c != 0);
        one   = ($countones(c) == 1);
        dig   = digit_of(c);
        case (m_mode)
            M_IDLE: if (e) begin m_mode = M_ENTER; m_ent.delete(); end
            M_ENTER: begin
                if (!e) m_mode = M_IDLE;
                else if (press) begin
                    if (!one) m_mode = M_ERROR;
                    else begin
                        m_ent.push_back(dig);
                        if (m_ent.size() == 4) begin m_mode = M_CONFIRM; m_conf = 0; end
                    end
                end
            end
            M_CONFIRM: begin
                if (!e) m_mode = M_IDLE;
                else if (press) begin
                    if (one && dig == m_ent[m_conf]) begin
                        m_conf++;
                        if (m_conf == 4) begin
                            m_mode = M_DONE;
                            m_pw   = 16'(m_ent[0] * 4096 + m_ent[1] * 256 + m_ent[2] * 16 + m_ent[3]);
                            m_upd  = 1'b1;
                            exp_commit_q.push_back(m_pw);
                        end
                    end else m_mode = M_ERROR;
                end
            end
            default: if (press) m_mode = M_IDLE;
        endcase
        m_prev = c;
    endtask

    function automatic logic [63:0] model_snapshot();
        logic [9:0]      st;
        logic [4:0][6:0] dd;
        int              n;
        dd = {5{7'b1111111}};
        st = 10'd1;
        n  = 0;
        case (m_mode)
            M_ENTER:   begin n = m_ent.size(); st = 10'((1 << (n + 1)) - 1); end
            M_CONFIRM: begin n = m_conf;       st = 10'((1 << (n + 5)) - 1); end
            M_DONE: begin
                st = 10'h1ff;
                for (int i = 0; i < 4; i++) dd[3 - i] = hex_seg(int'(m_pw[15 - 4 * i -: 4]));
            end
            M_ERROR: begin
                st = 10'h200;
                dd = {7'b0000110, 7'b0101111, 7'b0101111, 7'b0100011, 7'b0101111};
            end
            default: ;
        endcase
        if (m_mode == M_ENTER || m_mode == M_CONFIRM)
            for (int i = 0; i < n; i++) dd[3 - i] = 7'b0111111;
        return {st, m_mode == M_DONE, m_mode == M_ERROR, m_upd, m_pw,
                dd[4], dd[3], dd[2], dd[1], dd[0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply(input logic r, input logic e, input logic [9:0] c);
        rst     = r;
        prog_en = e;
        comb_in = c;
        model_step(r, e, c);
        exp_q.push_back(model_snapshot());
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic e, input logic [9:0] v, input int hold, input int gap);
        for (int i = 0; i < hold; i++) apply(1'b0, e, v);
        for (int i = 0; i < gap; i++) apply(1'b0, e, 10'd0);
    endtask

    function automatic logic [9:0] oh(input int d);
        logic [9:0] one = 10'd1;
        return one << d;
    endfunction

    task automatic press_rand(input int d);
        int r;
        int a;
        int b;
        r = $urandom_range(0, 31);
        if (r == 0) begin
            a = $urandom_range(0, 9);
            b = (a + 1 + $urandom_range(0, 8)) % 10;
            press(1'b1, oh(a) | oh(b), 1, 1);
        end else if (r == 1) begin
            press(1'b0, oh(d), 1, 1);
        end else if (r == 2) begin
            apply(1'b0, 1'b1, oh(d));
            apply(1'b0, 1'b1, oh((d + 3) % 10));
            apply(1'b0, 1'b1, 10'd0);
        end else if (r == 3) begin
            apply(1'b1, 1'b1, oh(d));
            apply(1'b0, 1'b1, 10'd0);
        end else begin
            press(1'b1, oh(d), $urandom_range(1, 3), $urandom_range(1, 2));
        end
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, 10'd0);
        apply(1'b1, 1'b0, 10'd0);
    endtask

    task automatic check_now(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic enter_seq(input int a, input int b, input int c, input int d);
        press(1'b1, oh(a), 1, 1);
        press(1'b1, oh(b), 1, 1);
        press(1'b1, oh(c), 1, 1);
        press(1'b1, oh(d), 1, 1);
    endtask

    // ---------------- monitor ----------------
    logic [63:0] exp_v;
    logic [63:0] act_v;
    logic [15:0] exp_c;
    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {states, saved, error, pw_update, pw_digits, d4, d3, d2, d1, d0};
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL snapshot cyc %0d: got %h expected %h", cyc, act_v, exp_v);
            end
        end
        if (pw_update === 1'b1) begin
            n_upd++;
            n_vec++;
            if (exp_commit_q.size() == 0) begin
                n_err++;
                $display("FAIL commit cyc %0d: got pulse with %h expected no pulse", cyc, pw_digits);
            end else begin
                exp_c = exp_commit_q.pop_front();
                if (pw_digits !== exp_c) begin
                    n_err++;
                    $display("FAIL commit cyc %0d: got %h expected %h", cyc, pw_digits, exp_c);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int upd_before;
    int dg[4];
    int dv;

    initial begin
        rst     = 1'b1;
        prog_en = 1'b0;
        comb_in = '0;
        m_mode  = M_IDLE;
        m_conf  = 0;
        m_pw    = 16'h9876;
        m_prev  = '0;
        m_upd   = 1'b0;

        // Reset state, then a full successful programming run
        do_reset();
        check_now("reset_pw", pw_digits, 16'h9876);
        check_now("reset_states", 16'(states), 16'h0001);
        check_now("reset_flags", {13'd0, pw_update, saved, error}, 16'h0000);
        check_now("reset_d4", 16'(d4), 16'h007f);
        upd_before = n_upd;
        apply(1'b0, 1'b1, 10'd0);
        enter_seq(1, 2, 3, 4);
        enter_seq(1, 2, 3, 4);
        check_now("commit_pw", pw_digits, 16'h1234);
        check_now("commit_states", 16'(states), 16'h01ff);
        check_now("commit_saved", 16'(saved), 16'h0001);
        check_now("commit_pulses", 16'(n_upd - upd_before), 16'h0001);

        // Confirm mismatch lands in ERROR without touching the stored password
        do_reset();
        apply(1'b0, 1'b1, 10'd0);
        enter_seq(1, 2, 3, 4);
        press(1'b1, oh(1), 1, 1);
        press(1'b1, oh(2), 1, 1);
        press(1'b1, oh(5), 1, 1);
        check_now("mismatch_pw", pw_digits, 16'h9876);
        check_now("mismatch_states", 16'(states), 16'h0200);
        check_now("mismatch_d4", 16'(d4), 16'h0006);
        check_now("mismatch_d1", 16'(d1), 16'h0023);

        // Multi-bit press in ENTER, then any press returns to IDLE
        do_reset();
        apply(1'b0, 1'b1, 10'd0);
        press(1'b1, 10'b0000000110, 1, 1);
        check_now("multibit_error", 16'(error), 16'h0001);
        press(1'b1, oh(3), 1, 0);
        check_now("error_exit_states", 16'(states), 16'h0001);
        apply(1'b0, 1'b0, 10'd0);

        // Held switch counts once; prog_en drop beats a same-cycle press
        do_reset();
        apply(1'b0, 1'b1, 10'd0);
        press(1'b1, oh(5), 10, 1);
        check_now("hold_states", 16'(states), 16'h0003);
        press(1'b1, oh(6), 1, 1);
        check_now("two_digit_states", 16'(states), 16'h0007);
        apply(1'b0, 1'b0, oh(7));
        check_now("abort_states", 16'(states), 16'h0001);
        check_now("abort_pw", pw_digits, 16'h9876);
        apply(1'b0, 1'b0, 10'd0);

        // Reset after a commit restores the default password
        do_reset();
        apply(1'b0, 1'b1, 10'd0);
        enter_seq(1, 2, 3, 4);
        enter_seq(1, 2, 3, 4);
        apply(1'b1, 1'b1, 10'd0);
        check_now("rst_after_commit_pw", pw_digits, 16'h9876);
        check_now("rst_after_commit_saved", 16'(saved), 16'h0000);
        check_now("rst_after_commit_d3", 16'(d3), 16'h007f);
        apply(1'b0, 1'b0, 10'd0);

        // Randomized programming attempts
        for (int a = 0; a < 60; a++) begin
            if ($urandom_range(0, 9) == 0) apply(1'b1, 1'($urandom_range(0, 1)), 10'($urandom));
            apply(1'b0, 1'b1, 10'd0);
            for (int i = 0; i < 4; i++) begin
                dg[i] = $urandom_range(0, 9);
                press_rand(dg[i]);
            end
            for (int i = 0; i < 4; i++) begin
                dv = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : dg[i];
                press_rand(dv);
            end
            press_rand($urandom_range(0, 9));
            apply(1'b0, 1'b0, 10'd0);
            apply(1'b0, 1'b0, 10'd0);
        end

        @(negedge clk);
        #1;
        check_now("exp_q_drained", 16'(exp_q.size()), 16'h0000);
        check_now("commit_q_drained", 16'(exp_commit_q.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
